// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the sequential GCD/LCM engine.
package gcd_lcm_pkg;

    // Top-level controller states
    typedef enum logic [2:0] {
        IDLE,
        GCD,
        DIV,
        MUL,
        DONE
    } gcd_state_e;

    // GCD algorithm selection
    localparam int MODE_SUB = 0;  // swap/subtract
    localparam int MODE_BIN = 1;  // binary (Stein)

endpackage

// File: rtl/seq_udiv_mul.sv
// Sequential divide-then-multiply datapath: q = dividend / divisor (restoring,
// MSB first), then prod = q * mcand (shift-add, MSB first). Each phase takes
// exactly DW steps and both phases share one iteration counter.
module seq_udiv_mul #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,      // load operands, clear counter and accumulator
    input  logic            run,        // advance one step of the current phase
    input  logic            mul_phase,  // 0: divide step, 1: multiply step
    input  logic [DW-1:0]   dividend,
    input  logic [DW-1:0]   divisor,
    input  logic [DW-1:0]   mcand,
    output logic            done,       // high during the last step of the current phase
    output logic [2*DW-1:0] prod        // final product, valid while done is high in the multiply phase
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   quo_q, quo_d;      // dividend shifts out, quotient shifts in; then feeds the multiplier
    logic [DW-1:0]   div_q, div_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW:0]     rem_sh;

    assign done = run && (cnt_q == CW'(DW - 1));
    assign prod = acc_d;

    // One divide or multiply step per cycle; the quotient register is reused as multiplier
    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        rem_sh  = {rem_q, quo_q[DW-1]};
        if (start) begin
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dividend;
            div_d   = divisor;
            mcand_d = mcand;
            acc_d   = '0;
        end else if (run) begin
            cnt_d = done ? '0 : cnt_q + CW'(1);
            if (!mul_phase) begin
                if (rem_sh >= {1'b0, div_q}) begin
                    rem_d = DW'(rem_sh - {1'b0, div_q});
                    quo_d = {quo_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b0};
                end
            end else begin
                acc_d = {acc_q[2*DW-2:0], 1'b0} + (quo_q[DW-1] ? {{DW{1'b0}}, mcand_q} : '0);
                quo_d = {quo_q[DW-2:0], 1'b0};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/gcd_lcm_seq.sv
// Multi-cycle GCD/LCM engine with valid/ready handshakes. The GCD runs
// iteratively (subtractive or Stein), then lcm = (a / gcd) * b is formed by the
// sequential divide/multiply datapath. Results are held until accepted.
module gcd_lcm_seq
    import gcd_lcm_pkg::*;
#(
    parameter int DW   = 8,
    parameter int MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   data_a,
    input  logic [DW-1:0]   data_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   gcd_o,
    output logic [2*DW-1:0] lcm_o,
    output logic            zero_o
);

    localparam int KW = $clog2(DW) + 1;

    gcd_state_e      state_q, state_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [DW-1:0]   x_q, x_d, y_q, y_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   g_q, g_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   gcd_q, gcd_d;
    logic [2*DW-1:0] lcm_q, lcm_d;
    logic            zero_q, zero_d;

    logic            dp_start, dp_run, dp_mul, dp_done;
    logic [2*DW-1:0] dp_prod;
    logic [DW-1:0]   gcd_val;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign gcd_o     = gcd_q;
    assign lcm_o     = lcm_q;
    assign zero_o    = zero_q;

    // Stein strips common factors of two into k; restore them when x meets y
    assign gcd_val = (MODE == MODE_BIN) ? (x_q << k_q) : x_q;
    assign dp_run  = (state_q == DIV) || (state_q == MUL);
    assign dp_mul  = (state_q == MUL);

    seq_udiv_mul #(.DW(DW)) u_divmul (
        .clk      (clk),
        .rst      (rst),
        .start    (dp_start),
        .run      (dp_run),
        .mul_phase(dp_mul),
        .dividend (a_q),
        .divisor  (gcd_val),
        .mcand    (b_q),
        .done     (dp_done),
        .prod     (dp_prod)
    );

    // Next-state logic for the controller and the GCD working registers
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        x_d         = x_q;
        y_d         = y_q;
        k_d         = k_q;
        g_d         = g_q;
        out_valid_d = out_valid_q;
        gcd_d       = gcd_q;
        lcm_d       = lcm_q;
        zero_d      = zero_q;
        dp_start    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d = data_a;
                    b_d = data_b;
                    x_d = data_a;
                    y_d = data_b;
                    k_d = '0;
                    if (data_a == '0 || data_b == '0) begin
                        // Result is known immediately; it is presented from DONE one cycle later
                        gcd_d   = data_a | data_b;
                        lcm_d   = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = GCD;
                    end
                end
            end
            GCD: begin
                if (x_q == y_q) begin
                    g_d      = gcd_val;
                    dp_start = 1'b1;
                    state_d  = DIV;
                end else if (MODE == MODE_SUB) begin
                    if (x_q > y_q) begin
                        x_d = x_q - y_q;
                    end else begin
                        x_d = y_q;
                        y_d = x_q;
                    end
                end else begin
                    unique case ({x_q[0], y_q[0]})
                        2'b00: begin
                            x_d = x_q >> 1;
                            y_d = y_q >> 1;
                            k_d = k_q + KW'(1);
                        end
                        2'b01:   x_d = x_q >> 1;
                        2'b10:   y_d = y_q >> 1;
                        default: begin
                            if (x_q > y_q) x_d = x_q - y_q;
                            else           y_d = y_q - x_q;
                        end
                    endcase
                end
            end
            DIV: begin
                if (dp_done) state_d = MUL;
            end
            MUL: begin
                if (dp_done) begin
                    gcd_d       = g_q;
                    lcm_d       = dp_prod;
                    zero_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // Controller state, working registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            g_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            gcd_q       <= '0;
            lcm_q       <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k_q         <= k_d;
            g_q         <= g_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            gcd_q       <= gcd_d;
            lcm_q       <= lcm_d;
            zero_q      <= zero_d;
        end
    end

endmodule

// File: tb/tb_gcd_lcm_seq.sv
// Bench for gcd_lcm_seq: subtractive and Stein 8-bit engines fed the same
// pairs, plus a 16-bit Stein engine. Expected results come from a vector table
// or a Euclid reference model and are queued per engine when a pair is sent.
module tb_gcd_lcm_seq;

    typedef struct {
        logic [7:0]  a, b, g;
        logic [15:0] l;
        logic        z;
        int          lat0, lat1;   // -1: latency not checked
    } vec_t;

    typedef struct {
        logic [7:0]  a, b, g;
        logic [15:0] l;
        logic        z;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  data_a, data_b;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, out_ready0, out_ready1;
    logic [7:0]  gcd0, gcd1;
    logic [15:0] lcm0, lcm1;
    logic        zero0, zero1;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16;
    logic [15:0] a16, b16, gcd16;
    logic [31:0] lcm16;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    int got0     = 0;
    int lat0, lat1;
    logic ov0_prev = 1'b0, ov1_prev = 1'b0;
    exp_t q0[$], q1[$];
    exp_t e0, e1;
    vec_t vecs[15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_lcm_seq #(.DW(8), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .data_a(data_a), .data_b(data_b), .out_valid(out_valid0), .out_ready(out_ready0),
        .gcd_o(gcd0), .lcm_o(lcm0), .zero_o(zero0)
    );

    gcd_lcm_seq #(.DW(8), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .data_a(data_a), .data_b(data_b), .out_valid(out_valid1), .out_ready(out_ready1),
        .gcd_o(gcd1), .lcm_o(lcm1), .zero_o(zero1)
    );

    gcd_lcm_seq #(.DW(16), .MODE(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .data_a(a16), .data_b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .gcd_o(gcd16), .lcm_o(lcm16), .zero_o(zero16)
    );

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic [7:0] t;
        while (y != 8'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_res(input string name, input exp_t e, input logic [7:0] g,
                             input logic [15:0] l, input logic z, input int lat);
        n_checks++;
        if (g !== e.g || l !== e.l || z !== e.z || (e.lat >= 0 && lat != e.lat)) begin
            n_fail++;
            $display("FAIL %s a=%0d b=%0d: got gcd=%0d lcm=%0d zero=%0d lat=%0d, expected gcd=%0d lcm=%0d zero=%0d lat=%0d",
                     name, e.a, e.b, g, l, z, lat, e.g, e.l, e.z, e.lat);
        end else begin
            $display("ok   %s a=%0d b=%0d gcd=%0d lcm=%0d zero=%0d lat=%0d", name, e.a, e.b, g, l, z, lat);
        end
    endtask

    // Scoreboard for the subtractive engine: pop on each accepted result
    always @(negedge clk) begin
        if (rst) begin
            ov0_prev = 1'b0;
        end else begin
            if (out_valid0 && !ov0_prev) lat0 = cyc - hs_cyc + 1;
            if (out_valid0 && out_ready0) begin
                got0++;
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut0_unexpected: got gcd=%0d lcm=%0d, expected no result", gcd0, lcm0);
                end else begin
                    e0 = q0.pop_front();
                    check_res("dut0", e0, gcd0, lcm0, zero0, lat0);
                end
            end
            ov0_prev = out_valid0;
        end
    end

    // Scoreboard for the Stein engine
    always @(negedge clk) begin
        if (rst) begin
            ov1_prev = 1'b0;
        end else begin
            if (out_valid1 && !ov1_prev) lat1 = cyc - hs_cyc + 1;
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut1_unexpected: got gcd=%0d lcm=%0d, expected no result", gcd1, lcm1);
                end else begin
                    e1 = q1.pop_front();
                    check_res("dut1", e1, gcd1, lcm1, zero1, lat1);
                end
            end
            ov1_prev = out_valid1;
        end
    end

    // Wait for both 8-bit engines to be ready, handshake one pair, queue expectations
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                        input logic [15:0] l, input logic z, input int la0, input int la1);
        int n = 0;
        @(negedge clk);
        while (!(in_ready0 && in_ready1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(in_ready0 && in_ready1)) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_ready a=%0d b=%0d: got in_ready=%b%b, expected 11", a, b, in_ready0, in_ready1);
            return;
        end
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        q0.push_back('{a, b, g, l, z, la0});
        q1.push_back('{a, b, g, l, z, la1});
        @(posedge clk);
        #1;
        hs_cyc   = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending results, expected 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                         input logic [31:0] l, input int want_lat);
        int n = 0;
        int h;
        int lat;
        @(negedge clk);
        while (!in_ready16 && n < 500) begin
            @(negedge clk);
            n++;
        end
        a16        = a;
        b16        = b;
        in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        h          = cyc;
        in_valid16 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid16 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("dut16_valid", {31'd0, out_valid16}, 32'd1);
        if (!out_valid16) return;
        lat = cyc - h + 1;
        $display("txn  dut16 a=%0d b=%0d gcd=%0d lcm=%0d zero=%0d lat=%0d", a, b, gcd16, lcm16, zero16, lat);
        chk("dut16_gcd", {16'd0, gcd16}, {16'd0, g});
        chk("dut16_lcm", lcm16, l);
        chk("dut16_zero", {31'd0, zero16}, 32'd0);
        if (want_lat >= 0) chk("dut16_lat", lat, want_lat);
        n_checks++;
        if (lat > 1 + 4 * 16 + 2 * 16) begin
            n_fail++;
            $display("FAIL dut16_lat_bound: got %0d, expected <= %0d", lat, 1 + 4 * 16 + 2 * 16);
        end
    endtask

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        int   base;
        logic [7:0] ra, rb, rg;
        logic [15:0] rl;

        vecs[0]  = '{8'd36,  8'd24,  8'd12,  16'd72,    1'b0, 21,  23};
        vecs[1]  = '{8'd24,  8'd36,  8'd12,  16'd72,    1'b0, 22,  23};
        vecs[2]  = '{8'd48,  8'd18,  8'd6,   16'd144,   1'b0, 24,  24};
        vecs[3]  = '{8'd255, 8'd254, 8'd1,   16'd64770, 1'b0, -1,  -1};
        vecs[4]  = '{8'd0,   8'd5,   8'd5,   16'd0,     1'b1, 2,   2};
        vecs[5]  = '{8'd0,   8'd0,   8'd0,   16'd0,     1'b1, 2,   2};
        vecs[6]  = '{8'd5,   8'd0,   8'd5,   16'd0,     1'b1, 2,   2};
        vecs[7]  = '{8'd1,   8'd1,   8'd1,   16'd1,     1'b0, 18,  18};
        vecs[8]  = '{8'd255, 8'd1,   8'd1,   16'd255,   1'b0, 272, 32};
        vecs[9]  = '{8'd128, 8'd64,  8'd64,  16'd128,   1'b0, -1,  -1};
        vecs[10] = '{8'd17,  8'd13,  8'd1,   16'd221,   1'b0, -1,  -1};
        vecs[11] = '{8'd200, 8'd150, 8'd50,  16'd600,   1'b0, -1,  -1};
        vecs[12] = '{8'd255, 8'd255, 8'd255, 16'd255,   1'b0, 18,  18};
        vecs[13] = '{8'd7,   8'd21,  8'd7,   16'd21,    1'b0, 21,  20};
        vecs[14] = '{8'd250, 8'd100, 8'd50,  16'd500,   1'b0, -1,  -1};

        rst         = 1'b1;
        in_valid    = 1'b0;
        data_a      = 8'd0;
        data_b      = 8'd0;
        out_ready0  = 1'b1;
        out_ready1  = 1'b1;
        in_valid16  = 1'b0;
        a16         = 16'd0;
        b16         = 16'd0;
        out_ready16 = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready0", {31'd0, in_ready0}, 32'd0);
        chk("rst_out_valid0", {31'd0, out_valid0}, 32'd0);
        chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        chk("rst_gcd0", {24'd0, gcd0}, 32'd0);
        chk("rst_lcm1", {16'd0, lcm1}, 32'd0);
        chk("rst_zero0", {31'd0, zero0}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready0", {31'd0, in_ready0}, 32'd1);
        chk("rel_in_ready1", {31'd0, in_ready1}, 32'd1);
        chk("rel_in_ready16", {31'd0, in_ready16}, 32'd1);

        // 16-bit Stein engine
        run16(16'd65535, 16'd65535, 16'd65535, 32'd65535, 34);
        run16(16'd1000, 16'd750, 16'd250, 32'd3000, -1);

        // Vector table on both 8-bit engines
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].l, vecs[i].z, vecs[i].lat0, vecs[i].lat1);
            drain();
        end

        // Random pairs against the Euclid model; both engines must agree with it
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rg = ref_gcd(ra, rb);
            rl = (ra == 8'd0 || rb == 8'd0) ? 16'd0 : 16'(ra / rg) * 16'(rb);
            send(ra, rb, rg, rl, (ra == 8'd0 || rb == 8'd0), -1, -1);
            drain();
        end

        // Backpressure: result held stable for 10 cycles, accepted exactly once
        out_ready0 = 1'b0;
        base = got0;
        send(8'd200, 8'd150, 8'd50, 16'd600, 1'b0, -1, -1);
        n = 0;
        @(negedge clk);
        while (!out_valid0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", {31'd0, out_valid0}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_gcd", {24'd0, gcd0}, 32'd50);
            chk("bp_lcm", {16'd0, lcm0}, 32'd600);
            chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid0}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        drain();
        @(posedge clk);
        #1;
        chk("bp_valid_drop", {31'd0, out_valid0}, 32'd0);
        chk("bp_count", 32'(got0 - base), 32'd1);

        // Reset in the middle of the divide phase aborts the pair
        send(8'd36, 8'd24, 8'd12, 16'd72, 1'b0, -1, -1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid0", {31'd0, out_valid0}, 32'd0);
        chk("mid_rst_in_ready0", {31'd0, in_ready0}, 32'd0);
        chk("mid_rst_in_ready1", {31'd0, in_ready1}, 32'd0);
        chk("mid_rst_gcd0", {24'd0, gcd0}, 32'd0);
        chk("mid_rst_lcm0", {16'd0, lcm0}, 32'd0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_in_ready0", {31'd0, in_ready0}, 32'd1);
        send(8'd7, 8'd21, 8'd7, 16'd21, 1'b0, 21, 20);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
